ifetch_prefetch_buffer: RTL
===========================

// Module: ifetch_prefetch_buffer
// PURPOSE
//  Instruction-fetch front end sitting directly upstream of the pipelined RV32 core.
//  Prefetches sequential words from a variable-latency instruction memory, queues them,
//  and presents InstrF for the core's PCF. Drives the core enable low while the needed
//  word is absent. Treats any non-sequential PCF as a redirect: flush and refetch.
// PARAMETERS
//  DEPTH     4             queue entries and max outstanding requests (power of 2, >=2)
//  RESET_PC  32'h0000_0000 first fetch address after reset; must equal core reset PC
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   asynchronous, active-low reset
//  pc_i            in   32  core PCF
//  instr_o         out  32  InstrF to core
//  core_en_o       out  1   core en; 1 = instr_o valid for pc_i
//  mem_req_valid_o out  1   fetch request valid
//  mem_req_ready_i in   1   memory accepts request
//  mem_req_addr_o  out  32  word-aligned fetch address
//  mem_rsp_valid_i in   1   response valid; responses in order, latency >=1 cycle
//  mem_rsp_data_i  in   32  response instruction word
// BEHAVIOUR
//  Reset: head_pc=fetch_pc=RESET_PC, queue count=0, inflight=0, drop=0;
//   core_en_o=0, instr_o=NOP (32'h0000_0013), mem_req_valid_o=0, mem_req_addr_o=RESET_PC.
//  Queue entry i holds word at head_pc+4*i; no PC tags stored.
//  Lookup (combinational on pc_i):
//   pc_i==head_pc   && count>=1 -> instr_o=entry0, core_en_o=1
//   pc_i==head_pc+4 && count>=2 -> instr_o=entry1, core_en_o=1
//   otherwise instr_o=NOP, core_en_o=0.
//  Advance: pc_i==head_pc+4 && count>=1 -> pop entry0, head_pc+=4 at edge.
//   pc_i==head_pc -> no pop (covers core stall / StallF).
//  Redirect: pc_i not in {head_pc, head_pc+4} -> at edge: count=0, head_pc=fetch_pc=pc_i,
//   drop+=inflight (incl. request accepted that same edge); core_en_o=0 that cycle.
//  Issue: mem_req_valid_o=1 when count+inflight<DEPTH and no redirect this cycle;
//   addr=fetch_pc. Once valid is asserted, valid and addr hold until ready (a redirect
//   while pending does not retarget it; its response is dropped, then refetch at pc_i).
//   Accept (valid&&ready): inflight+=1, fetch_pc+=4.
//  Response: drop>0 -> discard word, drop-=1; else write at tail, count+=1; inflight-=1.
//   Response + redirect same edge: word discarded, not counted into queue.
//  Simultaneous push+pop: count unchanged. count+inflight never exceeds DEPTH, so
//   responses never find the queue full; a response with inflight==0 is a protocol
//   error (assertion).
//  Address arithmetic mod 2^32; fetch_pc wraps 0xFFFF_FFFC->0 silently.
//  Reset asserted mid-operation: all state cleared asynchronously; responses to
//   pre-reset requests are the memory's responsibility to squash.
//  Min latency: memory latency L -> first core_en_o=1 L+1 cycles after first request.
// STRUCTURE
//  Package rv_fetch_pkg: NOP_INSTR constant, RESET_PC default, fetch_req_t struct.
//  Sub-module ifq_fifo: DEPTH-entry sync FIFO with flush, push, pop, peek of entries
//   0 and 1, count output. Top holds head_pc, fetch_pc, inflight, drop counters,
//   lookup/redirect logic.
// TESTING
//  1 Reset, memory latency 1, ready=1, core advances PC by 4 each cycle -> requests
//    0x0,0x4,0x8..; core_en_o=1 from cycle 2 onward with no bubbles.
//  2 Core holds pc_i=0x8 five cycles -> no pop, instr_o stable, queue fills to DEPTH=4,
//    mem_req_valid_o drops to 0 while count+inflight==4.
//  3 With 3 inflight, pc_i jumps 0x10->0x100 -> core_en_o=0, next 3 responses dropped,
//    next accepted address 0x100, first valid instr is word at 0x100.
//  4 ready=0 for 3 cycles with redirect at cycle 2 -> valid and addr held stable until
//    accepted; that word dropped; subsequent request addr = redirect target.
//  5 Response arrives same edge as redirect and same edge as push+pop -> word dropped /
//    count unchanged respectively; scoreboard matches memory model.
//  6 Assert rst low mid-burst with 2 inflight -> all outputs to reset values
//    immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package rv_fetch_pkg;

  // addi x0, x0, 0 -- presented to the core whenever no valid word is available.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // A fetch request parked on the memory port because memory was not ready.
  typedef struct packed {
    logic        valid;
    logic        stale;  // issued before a redirect; its word must be discarded
    logic [31:0] addr;
  } fetch_req_t;

  // Sequential word address; wraps silently at the top of the address space.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Instruction queue: DEPTH-entry synchronous FIFO with flush and a two-entry peek window.
module ifq_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [31:0]              peek0,
  output logic [31:0]              peek1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Write the incoming word at the tail; a flush in the same cycle wins.
  // NOTE: the data array has no reset on purpose -- count alone says which entries
  // are meaningful, and leaving storage unreset keeps it in plain RAM cells.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Oldest and second-oldest entries; only meaningful when count covers them.
  assign peek0 = mem[rd_ptr];
  assign peek1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction-fetch front end: prefetches sequential words, serves the core's PC from
// a small queue, stalls the core on a miss and refetches on any non-sequential PC.
module ifetch_prefetch_buffer
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic        core_en_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   head_pc;
  logic [31:0]   fetch_pc;
  logic [31:0]   head_pc_plus4;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [31:0]   entry0;
  logic [31:0]   entry1;
  fetch_req_t    pend;
  logic          run;

  logic          at_head;
  logic          at_next;
  logic          redirect;
  logic          pop;
  logic          push;
  logic          accept;
  logic          stale_accept;
  logic          can_issue;
  logic [CW:0]   occupancy;

  // Queue entry i always holds the word at head_pc + 4*i, so no tags are needed.
  assign head_pc_plus4 = next_word_addr(head_pc);
  assign at_head       = (pc_i == head_pc);
  assign at_next       = (pc_i == head_pc_plus4);
  assign redirect      = !at_head && !at_next;

  // Core moving on to the second entry retires the first one.
  assign pop  = at_next && (count != '0);
  // Words owed to an abandoned path, or landing on a redirect edge, are discarded.
  assign push = mem_rsp_valid_i && (drop == '0) && !redirect;

  assign inflight_next = inflight + CW'(accept) - CW'(mem_rsp_valid_i);

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (mem_rsp_data_i),
    .pop       (pop),
    .peek0     (entry0),
    .peek1     (entry1),
    .count     (count)
  );

  // Lookup: serve the core from the head entry or the one behind it.
  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    instr_o   = NOP_INSTR;
    core_en_o = 1'b0;
    if (at_head && count != '0) begin
      instr_o   = entry0;
      core_en_o = 1'b1;
    end else if (at_next && count >= CW'(2)) begin
      instr_o   = entry1;
      core_en_o = 1'b1;
    end
  end

  // Request port: a parked request keeps valid and address stable until memory takes it;
  // otherwise issue only when the queue can absorb every outstanding answer.
  always_comb begin
    occupancy       = {1'b0, count} + {1'b0, inflight};
    can_issue       = run && !redirect && (occupancy < DEPTH_W);
    mem_req_valid_o = pend.valid || can_issue;
    mem_req_addr_o  = pend.valid ? pend.addr : fetch_pc;
    accept          = mem_req_valid_o && mem_req_ready_i;
    stale_accept    = accept && pend.valid && pend.stale;
  end

  // Fetch state: head/fetch addresses, outstanding and to-be-dropped counts, parked request.
  // NOTE: sequential state uses non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_pc  <= RESET_PC;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      pend     <= '{valid: 1'b0, stale: 1'b0, addr: RESET_PC};
      run      <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight_next;
      if (redirect) begin
        head_pc  <= pc_i;
        fetch_pc <= pc_i;
        // Everything still outstanding after this edge belongs to the old path.
        // drop never exceeds inflight, so this also covers words already owed.
        drop     <= inflight_next;
      end else begin
        if (pop) head_pc <= head_pc_plus4;
        // A stale parked request going out does not advance the new path.
        if (accept && !stale_accept) fetch_pc <= next_word_addr(fetch_pc);
        drop <= drop - CW'(mem_rsp_valid_i && drop != '0) + CW'(stale_accept);
      end
      pend.valid <= mem_req_valid_o && !mem_req_ready_i;
      pend.stale <= mem_req_valid_o && !mem_req_ready_i &&
                    (redirect || (pend.valid && pend.stale));
      pend.addr  <= mem_req_addr_o;
    end
  end

  // An in-order memory can only answer requests it has accepted.
  rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
    mem_rsp_valid_i |-> (inflight != '0));

endmodule
